// File: rtl/spike_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spike_dispatch_pkg
// Purpose  : Shared dispatch FSM state encoding and default weight width.
// Revision : 1.0 - initial release
// ============================================================================
package spike_dispatch_pkg;

   localparam int c_WEIGHT_BITS = 8;

   typedef logic [1:0] state_t;

   localparam state_t c_ST_IDLE  = 2'd0;
   localparam state_t c_ST_FETCH = 2'd1;
   localparam state_t c_ST_CHECK = 2'd2;
   localparam state_t c_ST_EMIT  = 2'd3;

endpackage : spike_dispatch_pkg
`default_nettype wire

// File: rtl/spike_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : spike_dispatch
// Purpose  : Pops fired-neuron tags and walks each source row of the weight
//            memory, emitting (dst, weight) events with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module spike_dispatch
   import spike_dispatch_pkg::*;
#(
   parameter int NUMNEURONS = 2,
   parameter int TAGBITS    = 1,
   parameter int WEIGHTBITS = c_WEIGHT_BITS,
   parameter bit SKIP_ZERO  = 1'b1
) (
   input  logic                    clk,
   input  logic                    asyn_reset,
   input  logic                    run,
   input  logic                    fifo_empty,
   input  logic [TAGBITS-1:0]      fifo_tag,
   output logic                    fifo_deq,
   output logic                    w_rd,
   output logic [2*TAGBITS-1:0]    w_addr,
   input  logic [WEIGHTBITS-1:0]   w_data,
   output logic                    syn_valid,
   input  logic                    syn_ready,
   output logic [TAGBITS-1:0]      syn_dst,
   output logic [WEIGHTBITS-1:0]   syn_weight,
   output logic                    busy,
   output logic                    row_done,
   output logic [15:0]             spike_count
);

   localparam logic [TAGBITS-1:0] c_LAST_DST = TAGBITS'(NUMNEURONS - 1);

   state_t                  r_state;
   logic [TAGBITS-1:0]      r_src;
   logic [TAGBITS-1:0]      r_dst;
   logic [2*TAGBITS-1:0]    r_addr;
   logic [TAGBITS-1:0]      r_syn_dst;
   logic [WEIGHTBITS-1:0]   r_syn_weight;
   logic                    r_row_done;
   logic [15:0]             r_spike_count;

   logic                    w_pop;
   logic                    w_skip;
   logic                    w_accept;
   logic                    w_advance;
   logic                    w_last;
   logic [TAGBITS-1:0]      w_dst_inc;

   // Pop is gated by reset so the FIFO is never drained while held in reset.
   assign w_pop     = (r_state == c_ST_IDLE) && run && !fifo_empty && asyn_reset;
   assign w_skip    = (r_state == c_ST_CHECK) && SKIP_ZERO && (w_data == '0);
   assign w_accept  = (r_state == c_ST_EMIT) && syn_ready;
   assign w_advance = w_skip || w_accept;
   assign w_last    = (r_dst == c_LAST_DST);
   assign w_dst_inc = r_dst + TAGBITS'(1);

   always_ff @(posedge clk or negedge asyn_reset) begin
      if (!asyn_reset) begin
         r_state       <= c_ST_IDLE;
         r_src         <= '0;
         r_dst         <= '0;
         r_addr        <= '0;
         r_syn_dst     <= '0;
         r_syn_weight  <= '0;
         r_row_done    <= 1'b0;
         r_spike_count <= '0;
      end else begin
         r_row_done <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_pop) begin
                  r_src   <= fifo_tag;
                  r_dst   <= '0;
                  r_addr  <= {fifo_tag, {TAGBITS{1'b0}}};
                  r_state <= c_ST_FETCH;
               end
            end
            c_ST_FETCH: begin
               r_state <= c_ST_CHECK;
            end
            c_ST_CHECK: begin
               r_syn_weight <= w_data;
               r_syn_dst    <= r_dst;
               r_state      <= c_ST_EMIT;
            end
            default: begin
            end
         endcase

         // Advance overrides the CHECK->EMIT move when a zero weight is skipped.
         if (w_advance) begin
            if (w_last) begin
               r_row_done    <= 1'b1;
               r_spike_count <= r_spike_count + 16'd1;
               r_state       <= c_ST_IDLE;
            end else begin
               r_dst   <= w_dst_inc;
               r_addr  <= {r_src, w_dst_inc};
               r_state <= c_ST_FETCH;
            end
         end
      end
   end

   assign fifo_deq    = w_pop;
   assign w_rd        = (r_state == c_ST_FETCH);
   assign w_addr      = r_addr;
   assign syn_valid   = (r_state == c_ST_EMIT);
   assign syn_dst     = r_syn_dst;
   assign syn_weight  = r_syn_weight;
   assign busy        = (r_state != c_ST_IDLE);
   assign row_done    = r_row_done;
   assign spike_count = r_spike_count;

endmodule : spike_dispatch
`default_nettype wire

// File: tb/tb_spike_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_dispatch
// Purpose  : Directed self-checking bench for spike_dispatch (4 neurons).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_dispatch;

   localparam int c_N  = 4;
   localparam int c_TB = 2;
   localparam int c_WB = 8;

   logic            clk;
   logic            asyn_reset;
   logic            run;
   logic            run2;
   logic            fifo_empty;
   logic [c_TB-1:0] fifo_tag;
   logic            syn_ready;

   logic              fifo_deq,  fifo_deq2;
   logic              w_rd,      w_rd2;
   logic [2*c_TB-1:0] w_addr,    w_addr2;
   logic [c_WB-1:0]   w_data,    w_data2;
   logic              syn_valid, syn_valid2;
   logic [c_TB-1:0]   syn_dst,   syn_dst2;
   logic [c_WB-1:0]   syn_weight, syn_weight2;
   logic              busy,      busy2;
   logic              row_done,  row_done2;
   logic [15:0]       spike_count, spike_count2;

   logic [c_WB-1:0] mem [16];

   int checks = 0;
   int errors = 0;
   int deq_cnt = 0, deq2_cnt = 0;
   int rd_cnt = 0, rd2_cnt = 0;
   logic [9:0] ev[$];
   logic [9:0] ev2[$];
   logic found;

   spike_dispatch #(
      .NUMNEURONS(c_N), .TAGBITS(c_TB), .WEIGHTBITS(c_WB), .SKIP_ZERO(1'b1)
   ) dut (
      .clk(clk), .asyn_reset(asyn_reset), .run(run), .fifo_empty(fifo_empty),
      .fifo_tag(fifo_tag), .fifo_deq(fifo_deq), .w_rd(w_rd), .w_addr(w_addr),
      .w_data(w_data), .syn_valid(syn_valid), .syn_ready(syn_ready),
      .syn_dst(syn_dst), .syn_weight(syn_weight), .busy(busy),
      .row_done(row_done), .spike_count(spike_count)
   );

   spike_dispatch #(
      .NUMNEURONS(c_N), .TAGBITS(c_TB), .WEIGHTBITS(c_WB), .SKIP_ZERO(1'b0)
   ) dut2 (
      .clk(clk), .asyn_reset(asyn_reset), .run(run2), .fifo_empty(fifo_empty),
      .fifo_tag(fifo_tag), .fifo_deq(fifo_deq2), .w_rd(w_rd2), .w_addr(w_addr2),
      .w_data(w_data2), .syn_valid(syn_valid2), .syn_ready(syn_ready),
      .syn_dst(syn_dst2), .syn_weight(syn_weight2), .busy(busy2),
      .row_done(row_done2), .spike_count(spike_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle read latency weight memory, one port per instance.
   always @(posedge clk) begin
      if (w_rd)  w_data  <= mem[w_addr];
      if (w_rd2) w_data2 <= mem[w_addr2];
   end

   always @(posedge clk) begin
      if (syn_valid && syn_ready)   ev.push_back({syn_dst, syn_weight});
      if (syn_valid2 && syn_ready)  ev2.push_back({syn_dst2, syn_weight2});
      if (fifo_deq)  deq_cnt++;
      if (fifo_deq2) deq2_cnt++;
      if (row_done)  rd_cnt++;
      if (row_done2) rd2_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rd(input int target, input int which, input string tag);
      for (int i = 0; i < 100; i++) begin
         if (((which == 1) ? rd_cnt : rd2_cnt) >= target) break;
         @(negedge clk);
      end
      check(tag, (which == 1) ? rd_cnt : rd2_cnt, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h11;
      mem[4]  = 8'hFF; mem[5]  = 8'h04; mem[6]  = 8'h00; mem[7]  = 8'h02;
      mem[8]  = 8'h05; mem[9]  = 8'h00; mem[10] = 8'hFD; mem[11] = 8'h07;
      mem[12] = 8'h01; mem[13] = 8'h02; mem[14] = 8'h03; mem[15] = 8'h04;
      w_data = '0; w_data2 = '0;

      // Reset held with a poppable FIFO
      asyn_reset = 1'b0; run = 1'b1; run2 = 1'b0;
      fifo_empty = 1'b0; fifo_tag = 2'd2; syn_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_deq",   fifo_deq, 0);
      check("rst_rd",    w_rd, 0);
      check("rst_addr",  w_addr, 0);
      check("rst_valid", syn_valid, 0);
      check("rst_dst",   syn_dst, 0);
      check("rst_wt",    syn_weight, 0);
      check("rst_busy",  busy, 0);
      check("rst_rdone", row_done, 0);
      check("rst_count", spike_count, 0);
      check("rst_deqcnt", deq_cnt, 0);

      // Release: pop on the first enabled edge, row 2 = {5,0,-3,7}
      asyn_reset = 1'b1;
      #1 check("rel_deq", fifo_deq, 1);
      @(posedge clk); #1 fifo_empty = 1'b1;
      @(negedge clk);
      check("fetch_rd",   w_rd, 1);
      check("fetch_addr", w_addr, 4'h8);
      check("fetch_busy", busy, 1);
      check("fetch_deq",  fifo_deq, 0);
      @(negedge clk);
      check("check_valid", syn_valid, 0);
      @(negedge clk);
      check("emit_valid", syn_valid, 1);
      check("emit_dst",   syn_dst, 0);
      check("emit_wt",    syn_weight, 8'h05);
      wait_rd(1, 1, "row1_done");
      @(negedge clk);
      check("row1_busy",  busy, 0);
      check("row1_count", spike_count, 1);
      check("row1_deqs",  deq_cnt, 1);
      check("row1_nev",   ev.size(), 3);
      check("row1_ev0",   ev[0], 10'h005);
      check("row1_ev1",   ev[1], 10'h2FD);
      check("row1_ev2",   ev[2], 10'h307);

      // Backpressure on the first event of row 1 = {-1,4,0,2}
      ev.delete();
      syn_ready = 1'b0; fifo_tag = 2'd1; fifo_empty = 1'b0;
      @(posedge clk); #1 fifo_empty = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (syn_valid) break;
         @(negedge clk);
      end
      check("bp_valid_seen", syn_valid, 1);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", syn_valid, 1);
         check("bp_dst",   syn_dst, 0);
         check("bp_wt",    syn_weight, 8'hFF);
         @(negedge clk);
      end
      check("bp_none_yet", ev.size(), 0);
      syn_ready = 1'b1;
      wait_rd(2, 1, "row2_done");
      @(negedge clk);
      check("row2_nev",   ev.size(), 3);
      check("row2_ev0",   ev[0], 10'h0FF);
      check("row2_ev1",   ev[1], 10'h104);
      check("row2_ev2",   ev[2], 10'h302);
      check("row2_count", spike_count, 2);
      check("row2_deqs",  deq_cnt, 2);

      // Empty FIFO with run=1: nothing happens
      repeat (5) @(negedge clk);
      check("empty_deqs", deq_cnt, 2);
      check("empty_busy", busy, 0);

      // run dropped mid-row: row 3 = {1,2,3,4} still completes, no second pop
      ev.delete();
      fifo_tag = 2'd3; fifo_empty = 1'b0;
      @(posedge clk); #1 run = 1'b0;
      wait_rd(3, 1, "row3_done");
      repeat (5) @(negedge clk);
      check("row3_deqs",  deq_cnt, 3);
      check("row3_deq",   fifo_deq, 0);
      check("row3_busy",  busy, 0);
      check("row3_count", spike_count, 3);
      check("row3_nev",   ev.size(), 4);
      check("row3_ev0",   ev[0], 10'h001);
      check("row3_ev1",   ev[1], 10'h102);
      check("row3_ev2",   ev[2], 10'h203);
      check("row3_ev3",   ev[3], 10'h304);

      // Non-skipping instance: row 2 emits all four including (1,0)
      ev2.delete();
      fifo_tag = 2'd2; fifo_empty = 1'b0; run2 = 1'b1;
      @(posedge clk); #1 fifo_empty = 1'b1;
      wait_rd(1, 2, "nz_done");
      @(negedge clk);
      check("nz_nev",   ev2.size(), 4);
      check("nz_ev0",   ev2[0], 10'h005);
      check("nz_ev1",   ev2[1], 10'h100);
      check("nz_ev2",   ev2[2], 10'h2FD);
      check("nz_ev3",   ev2[3], 10'h307);
      check("nz_count", spike_count2, 1);
      check("nz_deqs",  deq2_cnt, 1);
      check("nz_other_deqs", deq_cnt, 3);
      run2 = 1'b0;

      // Reset during EMIT of dst=1 on row 1
      ev.delete();
      run = 1'b1; syn_ready = 1'b1; fifo_tag = 2'd1; fifo_empty = 1'b0;
      @(posedge clk); #1 fifo_empty = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (syn_valid && syn_dst == 2'd1) begin
            found = 1'b1;
            syn_ready = 1'b0;
         end
      end
      check("mr_emit_dst1", found, 1);
      #2 asyn_reset = 1'b0;
      #1;
      check("mr_valid", syn_valid, 0);
      check("mr_busy",  busy, 0);
      check("mr_count", spike_count, 0);
      check("mr_deq",   fifo_deq, 0);
      @(negedge clk) asyn_reset = 1'b1;
      repeat (5) @(negedge clk);
      check("mr_post_busy",  busy, 0);
      check("mr_post_count", spike_count, 0);
      check("mr_post_deqs",  deq_cnt, 4);
      check("mr_post_nev",   ev.size(), 1);
      check("mr_post_rdone", rd_cnt, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_spike_dispatch
`default_nettype wire

// File: doc/spike_dispatch.md
Name: spike_dispatch

Overview:
- Downstream consumer of the fire FIFO: pops one fired-neuron tag at a time and walks that source neuron's row of the synaptic weight memory.
- Emits one (destination tag, weight) event per nonzero synapse to the current-accumulation stage, with valid/ready backpressure.
- Sits between the fire FIFO and the per-neuron input-current accumulators in the Izhikevich update loop.

Parameters:
- numneurons, 2: number of neurons; row length and number of rows.
- tagbits, 1: neuron tag width; ceil(log2(numneurons)), minimum 1.
- weightbits, 8: signed two's-complement synaptic weight width.
- skip_zero, 1: 1 = zero weights produce no event; 0 = every destination emits.

Ports:
- clk  in  1  system clock, rising edge.
- asyn_reset  in  1  asynchronous, active-low reset.
- run  in  1  dispatch enable; sampled only in IDLE.
- fifo_empty  in  1  fire FIFO empty flag.
- fifo_tag  in  tagbits  fire FIFO head tag; valid when fifo_empty=0.
- fifo_deq  out  1  one-cycle pop pulse to the fire FIFO.
- w_rd  out  1  weight memory read strobe.
- w_addr  out  2*tagbits  read address {src, dst}.
- w_data  in  weightbits  read data, valid exactly 1 cycle after w_rd.
- syn_valid  out  1  event valid.
- syn_ready  in  1  accumulator accepts event.
- syn_dst  out  tagbits  destination neuron tag.
- syn_weight  out  weightbits  signed weight.
- busy  out  1  high in any state other than IDLE.
- row_done  out  1  one-cycle pulse when a source row finishes.
- spike_count  out  16  number of rows dispatched since reset; wraps 0xFFFF->0.

Behaviour:
- Reset (asyn_reset=0, immediate): state=IDLE; src=0, dst=0. All outputs 0: fifo_deq, w_rd, w_addr, syn_valid, syn_dst, syn_weight, busy, row_done, spike_count.
- Reset mid-row abandons the row; no further fifo_deq and no event for that row.
- States: IDLE, FETCH, CHECK, EMIT.
- IDLE:
  - If run=1 and fifo_empty=0: latch src<=fifo_tag, dst<=0, assert fifo_deq for exactly this cycle, go to FETCH.
  - Otherwise stay; fifo_deq=0.
  - fifo_deq is never asserted while fifo_empty=1 or outside this transition.
- FETCH: w_rd=1, w_addr={src,dst} for one cycle; go to CHECK.
- CHECK:
  - Register syn_weight<=w_data and syn_dst<=dst.
  - If skip_zero=1 and w_data==0: advance.
  - Else go to EMIT.
- EMIT:
  - syn_valid=1; syn_dst and syn_weight held stable until the handshake.
  - Handshake: syn_valid & syn_ready on a rising edge, then advance.
  - syn_valid is never withdrawn before the handshake.
- Advance:
  - If dst==numneurons-1: pulse row_done for one cycle, increment spike_count, go to IDLE.
  - Else dst<=dst+1 and go to FETCH.
  - Never compare against 2**tagbits, so non-power-of-two numneurons is handled.
- Latency: IDLE pop to first w_rd is 1 cycle; w_rd to syn_valid is 2 cycles with syn_ready=1. Minimum per destination: 3 cycles when emitting, 2 when skipping.
- run deasserted mid-row: the current row completes; no new pop.
- Back-to-back rows: after row_done, IDLE may pop on the next cycle if the FIFO is non-empty.
- A self-synapse (dst==src) is treated like any other synapse.
- w_rd is 0 outside FETCH; w_addr holds its last value.
- syn_valid is 0 outside EMIT.

Decomposition:
- Shared package: state encoding (IDLE=0, FETCH=1, CHECK=2, EMIT=3) and the weight width constant, reused by the accumulator stage.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Reset hold: asyn_reset=0 with run=1 and fifo_empty=0 -> all outputs 0, no fifo_deq. Release -> pop on the first enabled edge.
- Single row, numneurons=4, src=2, weights {5,0,-3,7}, syn_ready=1 -> events (0,5), (2,-3), (3,7); exactly one fifo_deq; row_done once; spike_count=1.
- skip_zero=0, same weights -> four events including (1,0).
- Backpressure: hold syn_ready=0 for 5 cycles on the first event -> syn_valid, syn_dst and syn_weight stable for the whole stall; exactly one event accepted.
- Empty/run gating:
  - fifo_empty=1 -> no fifo_deq, busy=0.
  - run dropped mid-row -> the row still completes and the FIFO is not popped again.
- Mid-row reset: assert reset during EMIT of dst=1 -> syn_valid=0 immediately. After release with the FIFO empty, stays IDLE; spike_count=0.
